pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Power-up and lock supervisor for the iCE40 SB_PLL40_CORE clock generator. Runs on the 12 MHz reference clock.
- Drives the PLL RESETB pin and watches the asynchronous LOCK output.
- Holds the design's system reset until lock has been stable for a programmable time.
- Retries PLL reset on lock timeout or lock chatter; latches a fail flag after a bounded number of retries.

Parameters:
- RESET_CYCLES, 16: clk cycles pll_resetb is held low per PLL reset pulse (>=1).
- LOCK_TIMEOUT, 12000: clk cycles to wait for lock after releasing RESETB (1 ms at 12 MHz).
- STABLE_CYCLES, 256: consecutive synchronized-lock cycles required before releasing sys_reset.
- MAX_RETRIES, 3: retries allowed per episode; MAX_RETRIES+1 attempts total before FAIL.
- CNT_W, 16: shared cycle counter width; must hold max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- RETRY_W, 4: retry_count width; must hold MAX_RETRIES.

Ports:
- clk, in, 1: 12 MHz reference clock (the same net that feeds the PLL).
- reset, in, 1: synchronous, active-high.
- locked_async, in, 1: PLL LOCK output, asynchronous to clk.
- clear_fail, in, 1: single-cycle pulse; restarts the sequence from FAIL.
- pll_resetb, out, 1: to PLL RESETB; 0 holds the PLL in reset.
- sys_reset, out, 1: active-high reset for downstream logic. Consumers in the PLL clock domain re-synchronize it.
- ready, out, 1: high only in RUN.
- fail, out, 1: high only in FAIL.
- retry_count, out, RETRY_W: retries used in the current episode.
- lock_loss_count, out, 8: lock losses seen in RUN; saturates at 255.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (port reset).
- Lock synchronizer:
  - locked_async passes through a 2-FF synchronizer to give lock_s; both flops reset to 0.
  - Latency from locked_async to lock_s is 2 clk edges.
- Output decode: Moore outputs decoded from the state register.
  - PLL_RST: pll_resetb=0, sys_reset=1, ready=0, fail=0.
  - WAIT_LOCK: pll_resetb=1, sys_reset=1.
  - STABILIZE: pll_resetb=1, sys_reset=1.
  - RUN: pll_resetb=1, sys_reset=0, ready=1.
  - FAIL: pll_resetb=0, sys_reset=1, fail=1.
- Reset: on any clk edge with reset=1:
  - state <= PLL_RST; counter, retry_count, lock_loss_count and synchronizer <= 0.
  - This applies from any state, including mid-operation.
- PLL_RST: counter increments. At counter==RESET_CYCLES-1, go to WAIT_LOCK and clear the counter. pll_resetb is therefore low for exactly RESET_CYCLES cycles.
- WAIT_LOCK:
  - If lock_s=1: go to STABILIZE, counter <= 0.
  - Else if counter==LOCK_TIMEOUT-1: timeout event.
  - Else: counter increments.
- STABILIZE:
  - If lock_s=0: timeout event (chatter counts as a failed attempt).
  - Else if counter==STABLE_CYCLES-1: go to RUN.
  - Else: counter increments.
- Timeout event:
  - If retry_count==MAX_RETRIES: go to FAIL.
  - Else: retry_count increments, go to PLL_RST, counter <= 0.
- RUN:
  - If lock_s=0: go to PLL_RST, counter <= 0, retry_count <= 0, lock_loss_count increments (saturating at 255).
  - sys_reset rises 3 clk edges after locked_async falls (2 synchronizer edges + 1 state edge).
- FAIL:
  - Stays in FAIL regardless of lock_s.
  - clear_fail=1 moves to PLL_RST with retry_count <= 0 and counter <= 0.
  - clear_fail is ignored in every other state.
- Simultaneous events:
  - reset wins over everything.
  - In WAIT_LOCK, lock_s=1 on the timeout cycle goes to STABILIZE (lock wins).
- retry_count and lock_loss_count hold their values in FAIL and RUN.

Test Plan:
All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Normal lock: release reset at edge 0; raise locked_async 5 cycles after pll_resetb rises -> pll_resetb low for exactly 4 cycles. sys_reset falls and ready rises 2+1+8 edges after locked_async rises. retry_count=0, fail=0.
2. Never lock (locked_async=0) -> 3 pll_resetb low pulses of 4 cycles, each followed by a 20-cycle high window. After the third timeout: fail=1, pll_resetb=0, sys_reset=1, retry_count=2.
3. Chatter: locked_async drops for 1 cycle while in STABILIZE -> retry_count=1, new 4-cycle reset pulse; ready stays 0 until a full 8-cycle clean lock is seen.
4. Lock loss in RUN: drop locked_async -> sys_reset=1 and ready=0 exactly 3 edges later. lock_loss_count=1, retry_count=0, and the full sequence re-runs to RUN.
5. From FAIL: clear_fail pulse with locked_async held 1 -> PLL_RST, then RUN with fail=0 and retry_count=0. clear_fail pulsed in RUN -> no effect.
6. reset asserted mid-STABILIZE after 300 forced lock losses -> all outputs return to reset values next edge. Before the reset, lock_loss_count reads 255 (saturated, no wrap).

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock supervisor with retry and fail latch
//
// Purpose: drives the PLL RESETB pin, watches the asynchronous LOCK output and
// holds the downstream system reset until lock has been stable long enough.
// Lock timeouts and lock chatter trigger a fresh PLL reset pulse. A bounded
// number of retries is allowed before a sticky fail state is latched.
//
// Ports:
//   clk             in   reference clock (same net that feeds the PLL)
//   reset           in   synchronous, active-high
//   locked_async    in   PLL LOCK, asynchronous to clk
//   clear_fail      in   single-cycle pulse, leaves FAIL only
//   pll_resetb      out  to PLL RESETB, 0 holds the PLL in reset
//   sys_reset       out  active-high reset for downstream logic
//   ready           out  high only in RUN
//   fail            out  high only in FAIL
//   retry_count     out  retries used in the current episode
//   lock_loss_count out  lock losses seen in RUN, saturating at 255

module pll_lock_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 12000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16,
  parameter int RETRY_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               locked_async,
  input  logic               clear_fail,
  output logic               pll_resetb,
  output logic               sys_reset,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_count,
  output logic [7:0]         lock_loss_count
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic [7:0]         loss_nxt;
  logic               lock_meta, lock_s;
  logic               timeout_evt;

  // State register, shared counter, episode counters and the 2-FF lock
  // synchronizer. The synchronizer is cleared by reset so a stale lock from
  // before reset cannot shortcut the sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_PLL_RST;
      cnt             <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
      lock_meta       <= 1'b0;
      lock_s          <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      retry_count     <= retry_nxt;
      lock_loss_count <= loss_nxt;
      lock_meta       <= locked_async;
      lock_s          <= lock_meta;
    end
  end

  // Next-state logic. A lock timeout and lock chatter during stabilization
  // share one path: both consume a retry or land in FAIL.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    retry_nxt   = retry_count;
    loss_nxt    = lock_loss_count;
    timeout_evt = 1'b0;

    case (state)
      ST_PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s) begin
          state_nxt = ST_STABILIZE;
          cnt_nxt   = '0;
        end else if (cnt == LOCK_LAST) begin
          timeout_evt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_STABILIZE: begin
        if (!lock_s) begin
          timeout_evt = 1'b1;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // Lock loss starts a new episode, so the retry budget is refilled.
        if (!lock_s) begin
          state_nxt = ST_PLL_RST;
          cnt_nxt   = '0;
          retry_nxt = '0;
          if (lock_loss_count != 8'hFF) begin
            loss_nxt = lock_loss_count + 8'd1;
          end
        end
      end
      ST_FAIL: begin
        if (clear_fail) begin
          state_nxt = ST_PLL_RST;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_PLL_RST;
        cnt_nxt   = '0;
      end
    endcase

    if (timeout_evt) begin
      cnt_nxt = '0;
      if (retry_count == RETRY_MAX) begin
        state_nxt = ST_FAIL;
      end else begin
        state_nxt = ST_PLL_RST;
        retry_nxt = retry_count + RETRY_W'(1);
      end
    end
  end

  // Moore output decode.
  always_comb begin
    pll_resetb = 1'b1;
    sys_reset  = 1'b1;
    ready      = 1'b0;
    fail       = 1'b0;
    case (state)
      ST_PLL_RST:   pll_resetb = 1'b0;
      ST_WAIT_LOCK: pll_resetb = 1'b1;
      ST_STABILIZE: pll_resetb = 1'b1;
      ST_RUN: begin
        sys_reset = 1'b0;
        ready     = 1'b1;
      end
      ST_FAIL: begin
        pll_resetb = 1'b0;
        fail       = 1'b1;
      end
      default:      pll_resetb = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - directed self-checking bench for pll_lock_sequencer

module tb_pll_lock_sequencer;

  logic       clk;
  logic       reset;
  logic       locked_async;
  logic       clear_fail;
  logic       pll_resetb;
  logic       sys_reset;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  int checks;
  int errors;
  int n;
  int bad;

  pll_lock_sequencer #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2),
    .CNT_W        (16),
    .RETRY_W      (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .locked_async   (locked_async),
    .clear_fail     (clear_fail),
    .pll_resetb     (pll_resetb),
    .sys_reset      (sys_reset),
    .ready          (ready),
    .fail           (fail),
    .retry_count    (retry_count),
    .lock_loss_count(lock_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts sampled cycles while pll_resetb is low, starting with the current one.
  task automatic measure_low(output int cnt);
    cnt = 0;
    while (!pll_resetb && cnt < 100) begin
      cnt++;
      step(1);
    end
  endtask

  task automatic measure_high(output int cnt);
    cnt = 0;
    while (pll_resetb && cnt < 100) begin
      cnt++;
      step(1);
    end
  endtask

  // Edges until ready rises, bounded.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 200) begin
      step(1);
      cnt++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_resetb"}, pll_resetb, 0);
    check({tag, "_sysrst"}, sys_reset, 1);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_retry"}, retry_count, 0);
    check({tag, "_loss"}, lock_loss_count, 0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    locked_async = 1'b0;
    clear_fail   = 1'b0;
    step(2);
    check_reset_state("rst");

    // 1. Normal lock.
    reset = 1'b0;
    measure_low(n);
    check("s1_low_len", n, 4);
    step(5);
    check("s1_wait_resetb", pll_resetb, 1);
    check("s1_wait_sysrst", sys_reset, 1);
    locked_async = 1'b1;
    wait_ready(n);
    check("s1_lock_to_ready", n, 11);
    check("s1_sysrst", sys_reset, 0);
    check("s1_retry", retry_count, 0);
    check("s1_fail", fail, 0);

    // 4. Lock loss in RUN.
    locked_async = 1'b0;
    step(2);
    check("s4_ready_hold", ready, 1);
    step(1);
    check("s4_ready", ready, 0);
    check("s4_sysrst", sys_reset, 1);
    check("s4_resetb", pll_resetb, 0);
    check("s4_loss", lock_loss_count, 1);
    check("s4_retry", retry_count, 0);
    locked_async = 1'b1;
    wait_ready(n);
    check("s4_relock", n, 13);
    check("s4_loss_run", lock_loss_count, 1);

    // 3. Chatter during STABILIZE.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(7);
    check("s3_stab_resetb", pll_resetb, 1);
    check("s3_stab_ready", ready, 0);
    locked_async = 1'b0;
    step(1);
    locked_async = 1'b1;
    step(1);
    check("s3_pre_retry", pll_resetb, 1);
    step(1);
    check("s3_retry_resetb", pll_resetb, 0);
    check("s3_retry", retry_count, 1);
    check("s3_ready", ready, 0);
    measure_low(n);
    check("s3_low_len", n, 4);
    wait_ready(n);
    check("s3_to_ready", n, 9);
    check("s3_retry_run", retry_count, 1);

    // 2. Never lock.
    locked_async = 1'b0;
    reset        = 1'b1;
    step(1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("s2_retry_pulse", retry_count, i);
      measure_low(n);
      check("s2_low_len", n, 4);
      measure_high(n);
      check("s2_high_len", n, 20);
    end
    check("s2_fail", fail, 1);
    check("s2_resetb", pll_resetb, 0);
    check("s2_sysrst", sys_reset, 1);
    check("s2_retry", retry_count, 2);
    check("s2_ready", ready, 0);

    // 5. Recovery from FAIL.
    locked_async = 1'b1;
    step(5);
    check("s5_fail_sticky", fail, 1);
    check("s5_retry_hold", retry_count, 2);
    clear_fail = 1'b1;
    step(1);
    clear_fail = 1'b0;
    check("s5_cleared", fail, 0);
    check("s5_resetb", pll_resetb, 0);
    check("s5_retry", retry_count, 0);
    wait_ready(n);
    check("s5_to_ready", n, 13);
    check("s5_fail_run", fail, 0);
    check("s5_retry_run", retry_count, 0);
    clear_fail = 1'b1;
    step(1);
    clear_fail = 1'b0;
    check("s5_clr_in_run_ready", ready, 1);
    check("s5_clr_in_run_resetb", pll_resetb, 1);
    step(2);
    check("s5_clr_in_run_later", ready, 1);

    // 6. Saturating lock-loss counter, then reset mid-STABILIZE.
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      locked_async = 1'b0;
      step(1);
      locked_async = 1'b1;
      step(2);
      wait_ready(n);
      if (n != 13) bad++;
    end
    check("s6_loop_timing", bad, 0);
    check("s6_loss_sat", lock_loss_count, 255);
    locked_async = 1'b0;
    step(1);
    locked_async = 1'b1;
    step(2);
    check("s6_loss_still_sat", lock_loss_count, 255);
    step(6);
    check("s6_stab_resetb", pll_resetb, 1);
    check("s6_stab_ready", ready, 0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_reset_state("s6_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
